// File: rtl/dmem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_pkg : shared types and constants for the data-memory responder |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    localparam logic [31:0] DMEM_ERR_RDATA = 32'h0;

    function automatic int dmem_idx_w(input int depth_words);
        return $clog2(depth_words);
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_array : single-port word array, synchronous write,            |
// |              combinational read of the supplied index              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    // Left without reset so the bench can preload or inspect it directly.
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[i_idx] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_idx];

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_responder : fixed-latency load/store responder with pipeline  |
// |                  stall for the MEM stage                           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        stall_o,
    output logic        busy_o
);

    localparam int IDX_W = dmem_idx_w(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    dmem_state_t      r_state;
    dmem_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_latch;

    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;

    logic             w_err;
    logic             w_ack;
    logic             w_mem_we;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_mem_rdata;
    logic [31:0]      w_load_data;

    assign w_err       = (r_addr[1:0] != 2'b00) || ((r_addr >> (IDX_W + 2)) != 32'd0);
    assign w_idx       = r_addr[IDX_W+1:2];
    // A reset landing on the response cycle aborts it: no ack, no commit.
    assign w_ack       = (r_state == ST_RESP) && !rst_i;
    assign w_mem_we    = w_ack && r_we && !w_err;
    assign w_load_data = w_err ? DMEM_ERR_RDATA : w_mem_rdata;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk_i),
        .i_we    (w_mem_we),
        .i_idx   (w_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_mem_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_i) begin
                    w_latch = 1'b1;
                    if (LATENCY == 1) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = c_CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_we    <= we_i;
                r_addr  <= addr_i;
                r_wdata <= wdata_i;
            end
            if (w_ack && !r_we) begin
                r_rdata <= w_load_data;
            end
        end
    end

    // Load data is visible in the ack cycle itself, then held by r_rdata.
    assign rdata_o = (w_ack && !r_we) ? w_load_data : r_rdata;
    assign ack_o   = w_ack;
    assign err_o   = w_ack && w_err;
    assign stall_o = req_i && !w_ack;
    assign busy_o  = (r_state != ST_IDLE);

endmodule : dmem_responder
`default_nettype wire
